bit_sel_window_sched: RTL and testbench
=======================================

# bit_sel_window_sched

Sequencing controller for the 8-to-4 sequential bit-selection unit. It accepts a job descriptor (start offset, stride, window count) and streams 8-bit words into the selector. Per word it issues the 3-bit shift command so that successive 4-bit windows walk through the words at the programmed stride. It also tracks the selector's one-cycle latency to flag the last result and signal job completion, and sits between the word source and the selector in the NoC datapath.

## Interface
- DATA_WIDTH, 8, word width; fixed at 8.
- COMMAND_WIDTH, 3, selector command width; fixed at 3.
- COUNT_WIDTH, 8, width of window count; max job = 2^COUNT_WIDTH-1 windows.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_cfg_valid  in  1  job descriptor valid.
- o_cfg_ready  out  1  descriptor accepted when both high; equals (state==IDLE).
- i_cfg_start  in  3  initial offset, legal 0..4.
- i_cfg_stride  in  3  offset increment per window, legal 0..4.
- i_cfg_count  in  COUNT_WIDTH  number of windows, legal >=1.
- o_cfg_err  out  1  registered 1-cycle pulse: illegal descriptor rejected.
- i_valid  in  1  source word valid.
- o_ready  out  1  source word accepted when i_valid & o_ready.
- i_data_bus  in  DATA_WIDTH  source word.
- i_out_ready  in  1  downstream can accept a selector result.
- o_sel_valid  out  1  to selector i_valid.
- o_sel_data_bus  out  DATA_WIDTH  to selector i_data_bus.
- o_sel_en  out  1  to selector i_en (freezes selector when low).
- o_sel_cmd  out  COMMAND_WIDTH  to selector i_cmd.
- o_last  out  1  high while the selector output holds the job's final window.
- o_busy  out  1  state != IDLE.
- o_done  out  1  registered 1-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, DRAIN. Reset: state IDLE; offset, remaining, last_q, o_cfg_err, o_done = 0.
- Command encoding: offset 0 -> 3'b000 (no shift); offset k in 1..4 -> {1'b1, k-1}. The selector then outputs data[k+3:k].
- IDLE:
  - on i_cfg_valid, if start>4, stride>4 or count==0: pulse o_cfg_err next cycle and stay IDLE.
  - otherwise latch stride, set offset=start, remaining=count, go RUN.
- RUN:
  - o_ready = i_out_ready; o_sel_en = i_out_ready.
  - issue = i_valid & o_ready; o_sel_valid = issue; o_sel_data_bus = i_data_bus (pass-through); o_sel_cmd = enc(offset).
  - on issue: offset <= offset+stride, minus 5 if the sum is >=5 (mod-5 wrap); remaining <= remaining-1.
  - issue with remaining==1: last_q <= 1, go DRAIN.
- DRAIN:
  - o_ready=0, o_sel_valid=0, o_sel_en=i_out_ready.
  - On the first cycle with i_out_ready=1, the final result is consumed: last_q <= 0, o_done <= 1, go IDLE.
- o_last = last_q. last_q only updates in cycles with o_sel_en=1, so it stays aligned with the frozen selector output.
- In IDLE: o_sel_en=1, o_sel_valid=0 (flushes the selector valid). o_sel_cmd=3'b000 and o_sel_data_bus=0 in IDLE and DRAIN.
- i_cfg_valid is ignored outside IDLE. A new job may be accepted in the cycle o_done is high.
- Reset asserted mid-job: immediate abort to IDLE, no o_done, counters cleared. Partial words are discarded.

## Timing
- Word accepted in cycle t (en=1). The selector result and matching o_last are visible in cycle t+1. Fixed 1-cycle latency, extended 1:1 by cycles with i_out_ready=0.
- Throughput: 1 window/cycle with i_valid=i_out_ready=1. A job of N windows completes with o_done in cycle t0+N+2, where t0 is the cfg accept cycle and there are no stalls.
- o_ready and o_sel_en are combinational from i_out_ready and state; there is no combinational path from i_valid to o_ready.
- o_cfg_err and o_done are registered, exactly one cycle wide.

## Test plan
- Reset: hold rst=0 for 2 cycles -> o_busy=0, o_done=0, o_cfg_err=0, o_last=0, o_cfg_ready=1.
- Job start=1, stride=1, count=4; words 8'h11, 8'h22, 8'h33, 8'h44 back-to-back -> cmds 100,101,110,111; selector outputs 8,8,6,4; o_last with the 4; o_done one cycle later.
- Wrap: start=4, stride=3, count=3, words 8'h55 -> offsets 4,2,0; cmds 111,101,000; outputs 5,5,5.
- Stall: i_out_ready=0 for 3 cycles mid-job -> no word accepted, o_sel_en=0, selector output and o_last held; resumes with no loss or duplication.
- Illegal cfg: start=5 -> o_cfg_err pulse, o_busy stays 0. count=0 gives the same response.
- Abort: rst=0 after 2 of 4 windows -> IDLE next cycle, no o_done. A new job start=0, stride=0, count=1 on word 8'hA5 -> output 5, o_last=1, o_done.

Source files
------------

// File: rtl/bit_sel_window_sched.sv
// Job sequencer for the 8-to-4 sequential bit selector: issues per-word
// shift commands at a programmed stride and tracks the selector latency.
module bit_sel_window_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int COMMAND_WIDTH = 3,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cfg_valid,
  output logic                     o_cfg_ready,
  input  logic [2:0]               i_cfg_start,
  input  logic [2:0]               i_cfg_stride,
  input  logic [COUNT_WIDTH-1:0]   i_cfg_count,
  output logic                     o_cfg_err,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_data_bus,
  input  logic                     i_out_ready,
  output logic                     o_sel_valid,
  output logic [DATA_WIDTH-1:0]    o_sel_data_bus,
  output logic                     o_sel_en,
  output logic [COMMAND_WIDTH-1:0] o_sel_cmd,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_offset;
  logic [2:0]             r_stride;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic                   r_last;
  logic                   r_cfg_err;
  logic                   r_done;

  logic                   w_cfg_fire;
  logic                   w_cfg_bad;
  logic                   w_load;
  logic                   w_issue;
  logic                   w_consume;
  logic                   w_final;
  logic [3:0]             w_sum;
  logic [3:0]             w_wrap;
  logic [2:0]             w_off_nxt;

  // offset 0 means no shift; offset k maps to {1, k-1}
  function automatic logic [COMMAND_WIDTH-1:0] f_enc(
    input logic [2:0] k
  );
    logic [2:0] km1;
    km1 = k - 3'd1;
    if (k == 3'd0)
      f_enc = '0;
    else
      f_enc = {1'b1, km1[1:0]};
  endfunction

  assign w_cfg_bad = (i_cfg_start > 3'd4) ||
                     (i_cfg_stride > 3'd4) ||
                     (i_cfg_count == '0);

  assign w_cfg_fire = i_cfg_valid && (r_state == S_IDLE);

  assign w_sum  = {1'b0, r_offset} + {1'b0, r_stride};
  assign w_wrap = w_sum - 4'd5;
  assign w_off_nxt = (w_sum >= 4'd5) ? w_wrap[2:0]
                                     : w_sum[2:0];

  assign w_final = (r_remaining == COUNT_WIDTH'(1));

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_issue        = 1'b0;
    w_consume      = 1'b0;
    o_cfg_ready    = 1'b0;
    o_ready        = 1'b0;
    o_sel_valid    = 1'b0;
    o_sel_en       = 1'b1;
    o_sel_cmd      = '0;
    o_sel_data_bus = '0;
    unique case (r_state)
      S_IDLE: begin
        o_cfg_ready = 1'b1;
        if (w_cfg_fire && !w_cfg_bad) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_ready        = i_out_ready;
        o_sel_en       = i_out_ready;
        w_issue        = i_valid && i_out_ready;
        o_sel_valid    = w_issue;
        o_sel_data_bus = i_data_bus;
        o_sel_cmd      = f_enc(r_offset);
        if (w_issue && w_final)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_sel_en = i_out_ready;
        if (i_out_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_offset    <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_last      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_fire && w_cfg_bad;
      r_done    <= w_consume;
      if (w_load) begin
        r_offset    <= i_cfg_start;
        r_stride    <= i_cfg_stride;
        r_remaining <= i_cfg_count;
      end else if (w_issue) begin
        r_offset    <= w_off_nxt;
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
      end
      // only moves when the selector is enabled, so it tracks its output
      if (w_issue && w_final)
        r_last <= 1'b1;
      else if (w_consume)
        r_last <= 1'b0;
    end
  end

  assign o_last    = r_last;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_bit_sel_window_sched.sv
// Directed bench for bit_sel_window_sched with a behavioural
// 8-to-4 selector on its outputs.
module tb_bit_sel_window_sched;

  logic       clk;
  logic       rst;
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [2:0] i_cfg_start;
  logic [2:0] i_cfg_stride;
  logic [7:0] i_cfg_count;
  logic       o_cfg_err;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data_bus;
  logic       i_out_ready;
  logic       o_sel_valid;
  logic [7:0] o_sel_data_bus;
  logic       o_sel_en;
  logic [2:0] o_sel_cmd;
  logic       o_last;
  logic       o_busy;
  logic       o_done;

  int total = 0;
  int bad   = 0;

  logic [3:0] sel_q;
  logic       sel_vq;
  logic [7:0] sh;

  bit_sel_window_sched dut (
    .clk            (clk),
    .rst            (rst),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_start    (i_cfg_start),
    .i_cfg_stride   (i_cfg_stride),
    .i_cfg_count    (i_cfg_count),
    .o_cfg_err      (o_cfg_err),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data_bus     (i_data_bus),
    .i_out_ready    (i_out_ready),
    .o_sel_valid    (o_sel_valid),
    .o_sel_data_bus (o_sel_data_bus),
    .o_sel_en       (o_sel_en),
    .o_sel_cmd      (o_sel_cmd),
    .o_last         (o_last),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sh = o_sel_data_bus;
    if (o_sel_cmd[2])
      sh = o_sel_data_bus >> ({1'b0, o_sel_cmd[1:0]} + 3'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= '0;
      sel_vq <= 1'b0;
    end else if (o_sel_en) begin
      sel_q  <= sh[3:0];
      sel_vq <= o_sel_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] s, input logic [2:0] d,
                     input logic [7:0] n);
    i_cfg_valid  = 1'b1;
    i_cfg_start  = s;
    i_cfg_stride = d;
    i_cfg_count  = n;
    #1;
    chk("cfg_ready", o_cfg_ready, 1);
    step();
    i_cfg_valid = 1'b0;
  endtask

  task automatic word(input logic [7:0] w, input logic [2:0] cmd,
                      input string tag);
    i_valid    = 1'b1;
    i_data_bus = w;
    #1;
    chk({tag, "_cmd"}, o_sel_cmd, cmd);
    chk({tag, "_svalid"}, o_sel_valid, 1);
    chk({tag, "_sdata"}, o_sel_data_bus, w);
  endtask

  initial begin
    rst          = 1'b0;
    i_cfg_valid  = 1'b0;
    i_cfg_start  = '0;
    i_cfg_stride = '0;
    i_cfg_count  = '0;
    i_valid      = 1'b0;
    i_data_bus   = '0;
    i_out_ready  = 1'b1;
    step();
    step();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_cfg_err, 0);
    chk("rst_last", o_last, 0);
    chk("rst_cfg_ready", o_cfg_ready, 1);
    rst = 1'b1;
    step();

    // basic job: start 1, stride 1, four words
    cfg(3'd1, 3'd1, 8'd4);
    chk("j1_busy", o_busy, 1);
    word(8'h11, 3'b100, "j1w0");
    step();
    word(8'h22, 3'b101, "j1w1");
    chk("j1_out0", sel_q, 4'h8);
    chk("j1_v0", sel_vq, 1);
    chk("j1_last0", o_last, 0);
    step();
    word(8'h33, 3'b110, "j1w2");
    chk("j1_out1", sel_q, 4'h8);
    step();
    word(8'h44, 3'b111, "j1w3");
    chk("j1_out2", sel_q, 4'h6);
    chk("j1_last2", o_last, 0);
    step();
    i_valid = 1'b0;
    #1;
    chk("j1_out3", sel_q, 4'h4);
    chk("j1_last3", o_last, 1);
    chk("j1_drain_ready", o_ready, 0);
    chk("j1_drain_cmd", o_sel_cmd, 0);
    chk("j1_drain_done", o_done, 0);
    step();
    chk("j1_done", o_done, 1);
    chk("j1_last_clr", o_last, 0);
    chk("j1_idle", o_busy, 0);
    step();
    chk("j1_done_pulse", o_done, 0);

    // wrap: offsets 4, 2, 0
    cfg(3'd4, 3'd3, 8'd3);
    word(8'h55, 3'b111, "j2w0");
    step();
    word(8'h55, 3'b101, "j2w1");
    chk("j2_out0", sel_q, 4'h5);
    step();
    word(8'h55, 3'b000, "j2w2");
    chk("j2_out1", sel_q, 4'h5);
    step();
    i_valid = 1'b0;
    #1;
    chk("j2_out2", sel_q, 4'h5);
    chk("j2_last", o_last, 1);
    step();
    chk("j2_done", o_done, 1);

    // stall: offsets 0, 2, 4 with three stalled cycles after word 0
    cfg(3'd0, 3'd2, 8'd3);
    word(8'hA6, 3'b000, "j3w0");
    step();
    for (int i = 0; i < 3; i++) begin
      i_out_ready = 1'b0;
      i_valid     = 1'b1;
      i_data_bus  = 8'h3C;
      #1;
      chk("j3_stall_ready", o_ready, 0);
      chk("j3_stall_en", o_sel_en, 0);
      chk("j3_stall_sv", o_sel_valid, 0);
      chk("j3_stall_hold", sel_q, 4'h6);
      chk("j3_stall_last", o_last, 0);
      step();
    end
    i_out_ready = 1'b1;
    word(8'h3C, 3'b101, "j3w1");
    chk("j3_out0", sel_q, 4'h6);
    step();
    word(8'h5A, 3'b111, "j3w2");
    chk("j3_out1", sel_q, 4'hF);
    step();
    i_valid     = 1'b0;
    i_out_ready = 1'b0;
    #1;
    chk("j3_out2", sel_q, 4'h5);
    chk("j3_last", o_last, 1);
    chk("j3_drain_en", o_sel_en, 0);
    step();
    chk("j3_hold_last", o_last, 1);
    chk("j3_hold_out", sel_q, 4'h5);
    chk("j3_no_done", o_done, 0);
    chk("j3_busy", o_busy, 1);
    i_out_ready = 1'b1;
    step();
    chk("j3_done", o_done, 1);
    chk("j3_last_clr", o_last, 0);

    // illegal descriptors
    cfg(3'd5, 3'd1, 8'd1);
    chk("bad_start_err", o_cfg_err, 1);
    chk("bad_start_busy", o_busy, 0);
    step();
    chk("bad_start_pulse", o_cfg_err, 0);
    cfg(3'd0, 3'd1, 8'd0);
    chk("bad_count_err", o_cfg_err, 1);
    chk("bad_count_busy", o_busy, 0);
    cfg(3'd1, 3'd5, 8'd2);
    chk("bad_stride_err", o_cfg_err, 1);
    chk("bad_stride_busy", o_busy, 0);
    step();

    // abort after two of four windows
    cfg(3'd0, 3'd1, 8'd4);
    word(8'h12, 3'b000, "j4w0");
    step();
    word(8'h34, 3'b100, "j4w1");
    step();
    i_valid = 1'b0;
    rst     = 1'b0;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_last", o_last, 0);
    step();
    chk("abort_no_done", o_done, 0);
    rst = 1'b1;
    step();
    chk("abort_idle_done", o_done, 0);
    cfg(3'd0, 3'd0, 8'd1);
    word(8'hA5, 3'b000, "j5w0");
    step();
    i_valid = 1'b0;
    #1;
    chk("j5_out", sel_q, 4'h5);
    chk("j5_last", o_last, 1);
    step();
    chk("j5_done", o_done, 1);
    chk("j5_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
